// File: rtl/mul_div_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package mul_div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  // Counter width for an N-bit operand: wide enough to hold N-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_mul_div_unit_adder.sv
// N-bit adder with carry in/out, shared by both multiply and divide datapaths.
module seq_mul_div_unit_adder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         input_carry,
  output logic         output_carry,
  output logic [N-1:0] sum
);

  assign {output_carry, sum} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, input_carry};

endmodule

// File: rtl/seq_mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock,
// with a start/busy/done handshake and a single shared N-bit adder.
module seq_mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           div_by_zero
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state;
  logic            mode_q;
  logic [N-1:0]    opnd_q;   // multiplicand (mul) or divisor (div)
  logic [2*N-1:0]  acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [CntW-1:0] cnt;

  logic [N-1:0]    add_a, add_b, add_sum;
  logic            add_cin, add_cout;
  logic [2*N-1:0]  acc_step;
  logic            dbz_req;
  logic            last;

  // Divide feeds the adder {R, next dividend bit} minus divisor; multiply adds the upper half.
  always_comb begin
    add_a   = acc[2*N-1:N];
    add_b   = opnd_q;
    add_cin = 1'b0;
    if (mode_q == MODE_DIV) begin
      add_a   = acc[2*N-2:N-1];
      add_b   = ~opnd_q;
      add_cin = 1'b1;
    end
  end

  seq_mul_div_unit_adder #(
    .N(N)
  ) u_adder (
    .x           (add_a),
    .y           (add_b),
    .input_carry (add_cin),
    .output_carry(add_cout),
    .sum         (add_sum)
  );

  always_comb begin
    acc_step = acc;
    if (mode_q == MODE_DIV) begin
      // Top bit of {R, bit} set or no borrow means the trial subtraction fits.
      if (acc[2*N-1] || add_cout) acc_step = {add_sum, acc[N-2:0], 1'b1};
      else                        acc_step = {acc[2*N-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {add_cout, add_sum, acc[N-1:1]};
      else        acc_step = {1'b0, acc[2*N-1:1]};
    end
  end

  assign dbz_req = (mode == MODE_DIV) && (y == '0);
  assign last    = (cnt == CntW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= MODE_MUL;
      opnd_q      <= '0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (last) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= acc_step;
          end
        end
        default: begin
          state <= IDLE;
          if (start) begin
            mode_q      <= mode;
            opnd_q      <= (mode == MODE_DIV) ? y : x;
            acc         <= {{N{1'b0}}, (mode == MODE_DIV) ? x : y};
            cnt         <= '0;
            div_by_zero <= 1'b0;
            if (dbz_req) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              result      <= {x, {N{1'b1}}};
            end else begin
              state  <= CALC;
              busy   <= 1'b1;
              result <= '0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div_unit.sv
// Bench for seq_mul_div_unit: directed handshake scenarios at N=8 plus a random
// back-to-back sweep at N=8 and N=16, checked against a queue of expected results.
module tb_seq_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start8, mode8, busy8, done8, dbz8;
  logic [7:0]  x8, y8;
  logic [15:0] res8;

  logic        start16, mode16, busy16, done16, dbz16;
  logic [15:0] x16, y16;
  logic [31:0] res16;

  typedef struct packed {
    logic [15:0] res;
    logic        dbz;
  } exp8_t;

  exp8_t       sb8[$];
  logic [31:0] sb16[$];

  int n_cmp  = 0;
  int n_fail = 0;

  seq_mul_div_unit #(.N(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start8),
    .mode       (mode8),
    .x          (x8),
    .y          (y8),
    .busy       (busy8),
    .done       (done8),
    .result     (res8),
    .div_by_zero(dbz8)
  );

  seq_mul_div_unit #(.N(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start16),
    .mode       (mode16),
    .x          (x16),
    .y          (y16),
    .busy       (busy16),
    .done       (done16),
    .result     (res16),
    .div_by_zero(dbz16)
  );

  function automatic exp8_t model8(input logic m, input logic [7:0] a, input logic [7:0] b);
    exp8_t e;
    if (m && b == 8'd0) begin
      e.res = {a, 8'hFF};
      e.dbz = 1'b1;
    end else begin
      e.res = m ? {a % b, a / b} : 16'(a) * 16'(b);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drives a start at the current sample point; returns one sample after the accept edge.
  task automatic accept8(input logic m, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    mode8  = m;
    x8     = a;
    y8     = b;
    sb8.push_back(model8(m, a, b));
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Samples until done8 or budget; k counts edges after the accept edge.
  task automatic wait_done8(input int budget, output int k, output bit seen, output int busy_cnt);
    seen     = 1'b0;
    busy_cnt = 0;
    for (k = 0; k <= budget; k++) begin
      if (done8) begin
        seen = 1'b1;
        return;
      end
      busy_cnt += int'(busy8);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start8  = 1'b0; mode8  = 1'b0; x8  = '0; y8  = '0;
    start16 = 1'b0; mode16 = 1'b0; x16 = '0; y16 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
    n_cmp++; if (dbz8 !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", dbz8); end
    n_cmp++; if (res8 !== 16'h0) begin n_fail++; $display("FAIL reset_result got %h want 0000", res8); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_max();
    int k, bc; bit seen; exp8_t e;
    accept8(1'b0, 8'd255, 8'd255);
    wait_done8(20, k, seen, bc);
    e = sb8.pop_front();
    n_cmp++; if (!seen || k != 8) begin n_fail++; $display("FAIL mul_latency seen=%0b edges=%0d want 8", seen, k); end
    n_cmp++; if (bc != 8) begin n_fail++; $display("FAIL mul_busy_cycles got %0d want 8", bc); end
    n_cmp++; if (res8 !== e.res || res8 !== 16'hFE01) begin n_fail++; $display("FAIL mul_max_result got %h want fe01", res8); end
    n_cmp++; if (busy8 !== 1'b0 || dbz8 !== 1'b0) begin n_fail++; $display("FAIL mul_done_flags busy=%b dbz=%b want 0 0", busy8, dbz8); end
    @(posedge clk); #1;
    n_cmp++; if (done8 !== 1'b0 || res8 !== 16'hFE01) begin n_fail++; $display("FAIL mul_hold done=%b result=%h want 0 fe01", done8, res8); end
  endtask

  task automatic test_back_to_back();
    int k, bc; bit seen; exp8_t e;
    accept8(1'b1, 8'd200, 8'd7);
    wait_done8(20, k, seen, bc);
    e = sb8.pop_front();
    n_cmp++; if (!seen || res8 !== e.res || res8 !== 16'h041C || dbz8 !== 1'b0) begin
      n_fail++; $display("FAIL div_200_7 seen=%0b result=%h dbz=%b want 041c 0", seen, res8, dbz8);
    end
    accept8(1'b0, 8'd3, 8'd5);  // start in the done cycle
    repeat (3) begin @(posedge clk); #1; end
    start8 = 1'b1; mode8 = 1'b1; x8 = 8'd9; y8 = 8'd0;  // ignored while busy
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(20, k, seen, bc);
    k += 4;
    e = sb8.pop_front();
    n_cmp++; if (!seen || k != 8) begin n_fail++; $display("FAIL b2b_latency seen=%0b edges=%0d want 8", seen, k); end
    n_cmp++; if (res8 !== e.res || dbz8 !== e.dbz) begin n_fail++; $display("FAIL b2b_mul_result got %h/%b want %h/%b", res8, dbz8, e.res, e.dbz); end
    @(posedge clk); #1;
    n_cmp++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin n_fail++; $display("FAIL b2b_idle done=%b busy=%b want 0 0", done8, busy8); end
  endtask

  task automatic test_div_zero();
    int k, bc; bit seen; exp8_t e;
    accept8(1'b1, 8'h5A, 8'h00);
    wait_done8(5, k, seen, bc);
    e = sb8.pop_front();
    n_cmp++; if (!seen || k != 0) begin n_fail++; $display("FAIL dbz_latency seen=%0b edges=%0d want 0", seen, k); end
    n_cmp++; if (res8 !== e.res || dbz8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL dbz_result result=%h dbz=%b busy=%b want 5aff 1 0", res8, dbz8, busy8);
    end
    @(posedge clk); #1;
    n_cmp++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin n_fail++; $display("FAIL dbz_after done=%b busy=%b want 0 0", done8, busy8); end
  endtask

  task automatic test_reset_abort();
    int k, bc; bit seen; exp8_t e;
    bit done_in_reset = 1'b0;
    accept8(1'b0, 8'd100, 8'd100);
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy8 !== 1'b0 || done8 !== 1'b0 || dbz8 !== 1'b0 || res8 !== 16'h0) begin
      n_fail++; $display("FAIL abort_async busy=%b done=%b dbz=%b result=%h want all 0", busy8, done8, dbz8, res8);
    end
    sb8.delete();
    repeat (4) begin @(posedge clk); #1; if (done8) done_in_reset = 1'b1; end
    rst_n = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (done8) done_in_reset = 1'b1; end
    n_cmp++; if (done_in_reset) begin n_fail++; $display("FAIL abort_no_done got done=1 want 0"); end
    accept8(1'b0, 8'd100, 8'd100);
    wait_done8(20, k, seen, bc);
    e = sb8.pop_front();
    n_cmp++; if (!seen || res8 !== e.res || res8 !== 16'h2710) begin
      n_fail++; $display("FAIL abort_retry seen=%0b result=%h want 2710", seen, res8);
    end
  endtask

  task automatic test_random_sweep();
    fork
      begin : sweep8
        int ops; int guard; bit ok; exp8_t e;
        ops = 0; ok = 1'b1;
        start8 = 1'b1; mode8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom_range(1, 255));
        sb8.push_back(model8(mode8, x8, y8));
        @(posedge clk); #1;
        while (ok && ops < 7000) begin
          guard = 0;
          while (!done8 && guard < 20) begin @(posedge clk); #1; guard++; end
          if (!done8 || sb8.size() == 0) begin
            n_cmp++; n_fail++; ok = 1'b0;
            $display("FAIL sweep8_timeout op=%0d done=%b want 1", ops, done8);
          end else begin
            e = sb8.pop_front();
            n_cmp++;
            if (res8 !== e.res || dbz8 !== e.dbz) begin
              n_fail++; $display("FAIL sweep8 op=%0d got %h/%b want %h/%b", ops, res8, dbz8, e.res, e.dbz);
            end
            ops++;
            if (ops < 7000) begin
              mode8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom_range(1, 255));
              sb8.push_back(model8(mode8, x8, y8));
            end else start8 = 1'b0;
            @(posedge clk); #1;
          end
        end
        start8 = 1'b0;
      end
      begin : sweep16
        int ops; int guard; bit ok; logic [31:0] e;
        ops = 0; ok = 1'b1;
        start16 = 1'b1; mode16 = 1'($urandom); x16 = 16'($urandom); y16 = 16'($urandom_range(1, 65535));
        sb16.push_back(mode16 ? {x16 % y16, x16 / y16} : 32'(x16) * 32'(y16));
        @(posedge clk); #1;
        while (ok && ops < 3000) begin
          guard = 0;
          while (!done16 && guard < 30) begin @(posedge clk); #1; guard++; end
          if (!done16 || sb16.size() == 0) begin
            n_cmp++; n_fail++; ok = 1'b0;
            $display("FAIL sweep16_timeout op=%0d done=%b want 1", ops, done16);
          end else begin
            e = sb16.pop_front();
            n_cmp++;
            if (res16 !== e || dbz16 !== 1'b0) begin
              n_fail++; $display("FAIL sweep16 op=%0d got %h/%b want %h/0", ops, res16, dbz16, e);
            end
            ops++;
            if (ops < 3000) begin
              mode16 = 1'($urandom); x16 = 16'($urandom); y16 = 16'($urandom_range(1, 65535));
              sb16.push_back(mode16 ? {x16 % y16, x16 / y16} : 32'(x16) * 32'(y16));
            end else start16 = 1'b0;
            @(posedge clk); #1;
          end
        end
        start16 = 1'b0;
      end
    join
  endtask

  initial begin
    test_reset();
    test_mul_max();
    test_back_to_back();
    test_div_zero();
    test_reset_abort();
    test_random_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
